// File: rtl/inst_rom_axil.sv
// ============================================================================
//  Module      : inst_rom_axil
//  Description : Instruction memory at the far end of the core fetch port.
//                Fetches are combinational from an internal word array, so
//                IF_ID captures rom_data_o on the same edge as the PC.
//                An AXI-Lite slave port lets the SoC load or inspect the
//                program image (boot loader / debug).
//  Ports       : clk, rst (asynchronous, active low)
//                rom_ce_i, rom_addr_i -> rom_data_o   core fetch port
//                s_aw* / s_w* / s_b*                  AXI-Lite write channel
//                s_ar* / s_r*                         AXI-Lite read channel
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_rom_axil #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    output logic [31:0] rom_data_o,

    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,

    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready
);

    localparam int         c_DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [1:0] c_OKAY   = 2'b00;
    localparam logic [1:0] c_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_EXEC = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rstate_t;

    // Word array; deliberately not reset so it maps onto RAM.
    logic [31:0] r_mem [c_DEPTH];

    wstate_t     r_wstate;
    rstate_t     r_rstate;

    logic        r_aw_held;
    logic        r_w_held;
    logic [31:2] r_awaddr;      // byte offset bits are never used
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_bvalid;
    logic [1:0]  r_bresp;

    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;

    // ------------------------------------------------------------------
    // Address decode: upper bits above the array must be zero.
    // ------------------------------------------------------------------
    logic                  w_fetch_ok;
    logic [DEPTH_LOG2-1:0] w_fetch_idx;
    logic                  w_aw_ok;
    logic [DEPTH_LOG2-1:0] w_aw_idx;
    logic                  w_ar_ok;
    logic [DEPTH_LOG2-1:0] w_ar_idx;

    assign w_fetch_ok  = (rom_addr_i[31:DEPTH_LOG2+2] == '0);
    assign w_fetch_idx = rom_addr_i[DEPTH_LOG2+1:2];
    assign w_aw_ok     = (r_awaddr[31:DEPTH_LOG2+2] == '0);
    assign w_aw_idx    = r_awaddr[DEPTH_LOG2+1:2];
    assign w_ar_ok     = (s_araddr[31:DEPTH_LOG2+2] == '0);
    assign w_ar_idx    = s_araddr[DEPTH_LOG2+1:2];

    // Byte-offset bits are architecturally ignored.
    logic w_unused;
    assign w_unused = &{1'b0, rom_addr_i[1:0], s_araddr[1:0], s_awaddr[1:0]};

    // ------------------------------------------------------------------
    // Fetch path: purely combinational, no state.
    // ------------------------------------------------------------------
    assign rom_data_o = (rom_ce_i && w_fetch_ok) ? r_mem[w_fetch_idx] : NOP_WORD;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic w_aw_hs;
    logic w_w_hs;
    logic w_mem_we;

    assign s_awready = (r_wstate == W_IDLE) && !r_aw_held;
    assign s_wready  = (r_wstate == W_IDLE) && !r_w_held;
    assign w_aw_hs   = s_awvalid && s_awready;
    assign w_w_hs    = s_wvalid && s_wready;
    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;

    // The state register is reset asynchronously, so while rst is low the
    // FSM sits in W_IDLE and no partial write can reach the array.
    assign w_mem_we  = (r_wstate == W_EXEC) && w_aw_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    // AW and W are captured independently, in any order.
                    if (w_aw_hs) begin
                        r_aw_held <= 1'b1;
                        r_awaddr  <= s_awaddr[31:2];
                    end
                    if (w_w_hs) begin
                        r_w_held <= 1'b1;
                        r_wdata  <= s_wdata;
                        r_wstrb  <= s_wstrb;
                    end
                    if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
                        r_wstate <= W_EXEC;
                    end
                end
                W_EXEC: begin
                    r_aw_held <= 1'b0;
                    r_w_held  <= 1'b0;
                    r_bvalid  <= 1'b1;
                    r_bresp   <= w_aw_ok ? c_OKAY : c_SLVERR;
                    r_wstate  <= W_RESP;
                end
                W_RESP: begin
                    if (s_bready) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                end
            endcase
        end
    end

    // Byte-strobed array write at the W_EXEC exit edge.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wstrb[b]) begin
                    r_mem[w_aw_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel: the array is sampled on the AR handshake edge, so a
    // write landing on the same edge is not seen (old value returned).
    // ------------------------------------------------------------------
    assign s_arready = (r_rstate == R_IDLE);
    assign s_rvalid  = r_rvalid;
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= c_OKAY;
        end else if (r_rstate == R_IDLE) begin
            if (s_arvalid) begin
                r_rdata  <= w_ar_ok ? r_mem[w_ar_idx] : 32'h0000_0000;
                r_rresp  <= w_ar_ok ? c_OKAY : c_SLVERR;
                r_rvalid <= 1'b1;
                r_rstate <= R_RESP;
            end
        end else begin
            if (s_rready) begin
                r_rvalid <= 1'b0;
                r_rstate <= R_IDLE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_rom_axil.sv
// ============================================================================
//  Module      : tb_inst_rom_axil
//  Description : Self-checking bench for inst_rom_axil. Directed steps plus
//                randomized AXI-Lite traffic and fetches, checked against a
//                byte-addressed reference model of the program image.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_rom_axil;

    localparam int          DL       = 10;
    localparam int          BYTES    = 4 << DL;        // 4 KiB image
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;

    inst_rom_axil #(.DEPTH_LOG2(DL), .NOP_WORD(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_i   (rom_ce_i),
        .rom_addr_i (rom_addr_i),
        .rom_data_o (rom_data_o),
        .s_awaddr   (s_awaddr),
        .s_awvalid  (s_awvalid),
        .s_awready  (s_awready),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_wvalid   (s_wvalid),
        .s_wready   (s_wready),
        .s_bresp    (s_bresp),
        .s_bvalid   (s_bvalid),
        .s_bready   (s_bready),
        .s_araddr   (s_araddr),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_rdata    (s_rdata),
        .s_rresp    (s_rresp),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference image as bytes; unwritten bytes stay X like the array.
    logic [7:0] model [BYTES];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return a < BYTES;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int base;
        base = (a / 4) * 4;
        return {model[base+3], model[base+2], model[base+1], model[base]};
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int base;
        if (!in_range(a)) return;
        base = (a / 4) * 4;
        for (int b = 0; b < 4; b++)
            if (s[b]) model[base+b] = d[8*b +: 8];
    endtask

    function automatic logic [31:0] fetch_exp(input logic ce, input logic [31:0] a);
        return (ce && in_range(a)) ? model_word(a) : NOP;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // AW and W presented together; response checked at its exact latency.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        s_awaddr = a; s_awvalid = 1'b1;
        s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
        check("wr_awready", s_awready, 1);
        check("wr_wready", s_wready, 1);
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        check("wr_bvalid_early", s_bvalid, 0);
        tick();
        check("wr_bvalid", s_bvalid, 1);
        check("wr_bresp", s_bresp, in_range(a) ? 2'b00 : 2'b10);
        model_write(a, d, s);
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        check("wr_bvalid_clr", s_bvalid, 0);
    endtask

    task automatic axi_read(input logic [31:0] a);
        s_araddr = a; s_arvalid = 1'b1;
        check("rd_arready", s_arready, 1);
        tick();
        s_arvalid = 1'b0;
        check("rd_rvalid", s_rvalid, 1);
        check("rd_rdata", s_rdata, in_range(a) ? model_word(a) : 32'h0);
        check("rd_rresp", s_rresp, in_range(a) ? 2'b00 : 2'b10);
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        check("rd_rvalid_clr", s_rvalid, 0);
    endtask

    task automatic fetch(input logic ce, input logic [31:0] a);
        rom_ce_i = ce; rom_addr_i = a;
        #1;
        check("fetch", rom_data_o, fetch_exp(ce, a));
    endtask

    initial begin : main
        logic [31:0] a, d, held_data, old_word;
        logic [3:0]  s;
        int          wait_cnt;

        rst = 1'b0;
        rom_ce_i = 1'b0; rom_addr_i = '0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;

        // ---- reset state ----
        repeat (3) tick();
        check("rst_bvalid", s_bvalid, 0);
        check("rst_rvalid", s_rvalid, 0);
        check("rst_rdata", s_rdata, 0);
        check("rst_bresp", s_bresp, 0);
        check("rst_rresp", s_rresp, 0);
        rst = 1'b1;
        tick();
        check("idle_awready", s_awready, 1);
        check("idle_wready", s_wready, 1);
        check("idle_arready", s_arready, 1);
        fetch(1'b0, 32'h4);

        // ---- full-word write, then fetch ----
        axi_write(32'h4, 32'h2001_0005, 4'hF);
        fetch(1'b1, 32'h4);
        check("fetch_0x4", rom_data_o, 32'h2001_0005);

        // ---- W leads AW by three cycles, partial strobe ----
        s_wdata = 32'hAAAA_BBBB; s_wstrb = 4'b0011; s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wfirst_wready", s_wready, 0);
            check("wfirst_awready", s_awready, 1);
            check("wfirst_bvalid", s_bvalid, 0);
            tick();
        end
        s_awaddr = 32'h4; s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        tick();
        check("wfirst_bvalid", s_bvalid, 1);
        check("wfirst_bresp", s_bresp, 0);
        model_write(32'h4, 32'hAAAA_BBBB, 4'b0011);
        s_bready = 1'b1; tick(); s_bready = 1'b0;
        axi_read(32'h4);
        check("merged_word", model_word(32'h4), 32'h2001_BBBB);

        // ---- out-of-range address ----
        axi_write(32'h1000, 32'hDEAD_BEEF, 4'hF);
        fetch(1'b1, 32'h1000);
        axi_read(32'h1000);

        // ---- read held with rready low; second AR must wait ----
        s_araddr = 32'h4; s_arvalid = 1'b1;
        tick();
        held_data = s_rdata;
        check("hold_first", held_data, model_word(32'h4));
        s_araddr = 32'h1000;                 // second request stays pending
        for (int i = 0; i < 5; i++) begin
            check("hold_rvalid", s_rvalid, 1);
            check("hold_rdata", s_rdata, held_data);
            check("hold_rresp", s_rresp, 0);
            check("hold_arready", s_arready, 0);
            tick();
        end
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        check("hold_rvalid_clr", s_rvalid, 0);
        check("hold_arready_back", s_arready, 1);
        tick();
        s_arvalid = 1'b0;
        check("second_rvalid", s_rvalid, 1);
        check("second_rresp", s_rresp, 2'b10);
        check("second_rdata", s_rdata, 0);
        s_rready = 1'b1; tick(); s_rready = 1'b0;

        // ---- concurrent write and read/fetch of the same word ----
        axi_write(32'h8, 32'h1111_2222, 4'hF);
        old_word = model_word(32'h8);
        s_awaddr = 32'h8; s_awvalid = 1'b1;
        s_wdata = 32'h3333_4444; s_wstrb = 4'hF; s_wvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        fetch(1'b1, 32'h8);                  // array written on the next edge
        s_araddr = 32'h8; s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        check("coll_rdata_old", s_rdata, old_word);
        check("coll_bvalid", s_bvalid, 1);
        model_write(32'h8, 32'h3333_4444, 4'hF);
        fetch(1'b1, 32'h8);
        s_bready = 1'b1; s_rready = 1'b1;
        tick();
        s_bready = 1'b0; s_rready = 1'b0;

        // ---- reset while a write response is pending ----
        s_awaddr = 32'hC; s_awvalid = 1'b1;
        s_wdata = 32'h5555_6666; s_wstrb = 4'hF; s_wvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        tick();
        check("prerst_bvalid", s_bvalid, 1);
        model_write(32'hC, 32'h5555_6666, 4'hF);
        #2 rst = 1'b0;
        #1;
        check("asyncrst_bvalid", s_bvalid, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("postrst_bvalid", s_bvalid, 0);
        end
        check("postrst_awready", s_awready, 1);
        check("postrst_wready", s_wready, 1);
        fetch(1'b1, 32'hC);

        // ---- latched W is discarded by reset ----
        s_wdata = 32'h7777_8888; s_wstrb = 4'hF; s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        check("wlatch_wready", s_wready, 0);
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("wdrop_wready", s_wready, 1);
        s_awaddr = 32'h10; s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        repeat (3) tick();
        check("wdrop_no_bvalid", s_bvalid, 0);
        check("wdrop_awready", s_awready, 0);
        s_wdata = 32'h9999_AAAA; s_wstrb = 4'hF; s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        wait_cnt = 0;
        while (s_bvalid !== 1'b1 && wait_cnt < 10) begin
            tick();
            wait_cnt++;
        end
        check("wdrop_bvalid", s_bvalid, 1);
        model_write(32'h10, 32'h9999_AAAA, 4'hF);
        s_bready = 1'b1; tick(); s_bready = 1'b0;
        fetch(1'b1, 32'h10);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 16; i++)
            axi_write(32'(i * 4), $urandom, 4'hF);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0)
                a = $urandom | 32'h0000_1000;
            else
                a = 32'($urandom_range(0, 63));
            case ($urandom_range(0, 2))
                0: begin
                    d = $urandom;
                    s = 4'($urandom_range(0, 15));
                    axi_write(a, d, s);
                end
                1: axi_read(a);
                default: fetch(1'($urandom_range(0, 1)), a);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
